// File: rtl/matrix_scanner.sv
// matrix_scanner: self-timed LED-matrix row scanner with a double-buffered frame image.
// An internal row counter and dwell timer step through the rows. Each row slot starts
// with a blanking window. A newly loaded image is swapped in only at a frame boundary,
// so a frame is never shown half old and half new.
//
// Ports:
//   clk          in   1          system clock, rising edge
//   reset        in   1          synchronous active-high reset
//   enable       in   1          scanning enable; low forces timer to row 0 / tick 0
//   input_matrix in   PIXEL      new frame image, bit j*COL+i = row j, column i, 1 = lit
//   load         in   1          strobe: capture input_matrix
//   j_out        out  COL        column drive (registered)
//   row_out      out  ROW        one-hot row select (registered)
//   count        out  BIT_COUNT  row index of the displayed state (registered)
//   frame_start  out  1          pulse when outputs reflect row 0, tick 0
//   pending      out  1          a captured frame waits for the next boundary
module matrix_scanner #(
    parameter int unsigned ROW            = 4,
    parameter int unsigned COL            = 4,
    parameter int unsigned PIXEL          = ROW * COL,
    parameter int unsigned BIT_COUNT      = 2,
    parameter int unsigned DWELL          = 1000,
    parameter int unsigned BLANK          = 16,
    parameter int unsigned COL_ACTIVE_LOW = 1,
    parameter int unsigned ROW_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PIXEL-1:0]     input_matrix,
    input  logic                 load,
    output logic [COL-1:0]       j_out,
    output logic [ROW-1:0]       row_out,
    output logic [BIT_COUNT-1:0] count,
    output logic                 frame_start,
    output logic                 pending
);

    localparam int unsigned TW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic        COL_OFF = (COL_ACTIVE_LOW != 0);
    localparam logic        ROW_OFF = (ROW_ACTIVE_LOW != 0);

    logic [TW-1:0]        tick_q,    tick_d;
    logic [BIT_COUNT-1:0] cnt_q,     cnt_d;
    logic [PIXEL-1:0]     active_q,  active_d;
    logic [PIXEL-1:0]     pbuf_q,    pbuf_d;
    logic                 pend_q,    pend_d;
    logic [COL-1:0]       j_out_q,   j_out_d;
    logic [ROW-1:0]       row_out_q, row_out_d;
    logic [BIT_COUNT-1:0] count_q,   count_d;
    logic                 fs_q,      fs_d;

    logic                 boundary;
    logic                 drive;
    logic [COL-1:0]       row_bits;

    // Next-state: timer, buffers and registered output values
    always_comb begin
        tick_d    = tick_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pbuf_d    = pbuf_q;
        pend_d    = pend_q;
        j_out_d   = {COL{COL_OFF}};
        row_out_d = {ROW{ROW_OFF}};
        count_d   = '0;
        fs_d      = 1'b0;
        row_bits  = '0;

        // While enabled, state (0,0) occurs for exactly one cycle per frame: after
        // reset, after re-enable, or right after the row counter wraps.
        boundary = enable && (tick_q == '0) && (cnt_q == '0);
        drive    = enable && (int'(tick_q) >= int'(BLANK));

        if (!enable) begin
            tick_d = '0;
            cnt_d  = '0;
        end else if (tick_q == TW'(DWELL - 1)) begin
            tick_d = '0;
            cnt_d  = (cnt_q == BIT_COUNT'(ROW - 1)) ? '0 : cnt_q + BIT_COUNT'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end

        // Last load before the boundary wins.
        if (load) begin
            pbuf_d = input_matrix;
            pend_d = 1'b1;
        end

        // A load coinciding with the boundary bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                active_d = input_matrix;
            end else if (pend_q) begin
                active_d = pbuf_q;
            end
            pend_d = 1'b0;
        end

        // Display from active_d so row 0 of a new frame already shows the new image.
        row_bits = COL'(active_d >> (32'(cnt_q) * COL));
        if (drive) begin
            j_out_d = row_bits ^ {COL{COL_OFF}};
            for (int r = 0; r < int'(ROW); r++) begin
                row_out_d[r] = (cnt_q == BIT_COUNT'(r)) ? ~ROW_OFF : ROW_OFF;
            end
        end
        count_d = enable ? cnt_q : '0;
        fs_d    = boundary;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            pbuf_q    <= '0;
            pend_q    <= 1'b0;
            j_out_q   <= {COL{COL_OFF}};
            row_out_q <= {ROW{ROW_OFF}};
            count_q   <= '0;
            fs_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pbuf_q    <= pbuf_d;
            pend_q    <= pend_d;
            j_out_q   <= j_out_d;
            row_out_q <= row_out_d;
            count_q   <= count_d;
            fs_q      <= fs_d;
        end
    end

    assign j_out       = j_out_q;
    assign row_out     = row_out_q;
    assign count       = count_q;
    assign frame_start = fs_q;
    assign pending     = pend_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: scoreboard bench for matrix_scanner (4x4, DWELL=8).
// dut  : BLANK=2, columns active-low, rows active-high.
// dut2 : BLANK=0, columns active-high, rows active-low.
// Expected outputs come from a scan-position model: position s (cycles since the
// frame started) gives row = (s/8)%4 and tick = s%8, shown one cycle later.
`timescale 1ns/1ps
module tb_matrix_scanner;

    typedef struct packed {
        logic [3:0] j;
        logic [3:0] r;
        logic [1:0] c;
        logic       fs;
        logic       pd;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, load;
    logic [15:0] in_m;
    logic [3:0]  j_out, row_out;
    logic [1:0]  count;
    logic        frame_start, pending;

    logic        reset2, enable2, load2;
    logic [15:0] in2;
    logic [3:0]  j_out2, row_out2;
    logic [1:0]  count2;
    logic        frame_start2, pending2;

    matrix_scanner #(
        .ROW(4), .COL(4), .BIT_COUNT(2), .DWELL(8), .BLANK(2),
        .COL_ACTIVE_LOW(1), .ROW_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .input_matrix(in_m), .load(load),
        .j_out(j_out), .row_out(row_out), .count(count),
        .frame_start(frame_start), .pending(pending)
    );

    matrix_scanner #(
        .ROW(4), .COL(4), .BIT_COUNT(2), .DWELL(8), .BLANK(0),
        .COL_ACTIVE_LOW(0), .ROW_ACTIVE_LOW(1)
    ) dut2 (
        .clk(clk), .reset(reset2), .enable(enable2), .input_matrix(in2), .load(load2),
        .j_out(j_out2), .row_out(row_out2), .count(count2),
        .frame_start(frame_start2), .pending(pending2)
    );

    int   checks   = 0;
    int   failures = 0;
    int   s;
    obs_t sb[$];

    // Expected outputs for scan position s with image im.
    function automatic obs_t expect_at(int sp, logic [15:0] im, logic pd,
                                       logic cal, logic ral, int blank);
        obs_t       e;
        int         row;
        int         tk;
        logic [3:0] bits;
        row  = (sp / 8) % 4;
        tk   = sp % 8;
        bits = im[row*4 +: 4];
        e.c  = 2'(row);
        e.fs = ((sp % 32) == 0);
        e.pd = pd;
        if (tk < blank) begin
            e.j = {4{cal}};
            e.r = {4{ral}};
        end else begin
            e.j = bits ^ {4{cal}};
            e.r = 4'(1 << row) ^ {4{ral}};
        end
        return e;
    endfunction

    task automatic test_reset();
        obs_t got, exp;
        exp.j = 4'b1111; exp.r = 4'b0000; exp.c = 2'd0; exp.fs = 1'b0; exp.pd = 1'b0;
        for (int n = 0; n < 3; n++) begin
            sb.push_back(exp);
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_state cycle=%0d got=%b exp=%b", n, got, exp);
            end
        end
        // Release; the load coincides with the first boundary.
        reset = 1'b0; load = 1'b1; in_m = 16'h8421; s = 0;
    endtask

    task automatic test_scan();
        obs_t got, exp;
        for (int n = 0; n < 32; n++) begin
            sb.push_back(expect_at(s, 16'h8421, 1'b0, 1'b1, 1'b0, 2));
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL scan s=%0d got=%b exp=%b", s, got, exp);
            end
            s++;
            load = 1'b0;
        end
    endtask

    task automatic test_double_buffer();
        obs_t got, exp;
        for (int n = 0; n < 64; n++) begin
            sb.push_back(expect_at(s, (s < 64) ? 16'h8421 : 16'hFFFF,
                                   (s >= 50 && s < 64), 1'b1, 1'b0, 2));
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL double_buffer s=%0d got=%b exp=%b", s, got, exp);
            end
            s++;
            load = (s == 50);
            in_m = 16'hFFFF;
        end
    endtask

    task automatic test_coincident();
        obs_t got, exp;
        for (int n = 0; n < 64; n++) begin
            sb.push_back(expect_at(s, (s < 128) ? 16'hFFFF : 16'h0001,
                                   (s >= 110 && s < 128), 1'b1, 1'b0, 2));
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL coincident s=%0d got=%b exp=%b", s, got, exp);
            end
            s++;
            load = (s == 110) || (s == 128);
            in_m = (s == 128) ? 16'h0001 : 16'hFFFF;
        end
        load = 1'b0;
    endtask

    task automatic test_enable_drop();
        obs_t got, exp, off;
        off.j = 4'b1111; off.r = 4'b0000; off.c = 2'd0; off.fs = 1'b0; off.pd = 1'b0;
        // Run up to row 2, tick 4; the state at row 2, tick 5 sees enable low.
        for (int n = 0; n < 21; n++) begin
            sb.push_back(expect_at(s, 16'h0001, 1'b0, 1'b1, 1'b0, 2));
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pre_drop s=%0d got=%b exp=%b", s, got, exp);
            end
            s++;
        end
        enable = 1'b0;
        for (int n = 0; n < 4; n++) begin
            sb.push_back(off);
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL disabled n=%0d got=%b exp=%b", n, got, exp);
            end
        end
        // Restart at row 0; also exercise last-load-wins across the next boundary.
        enable = 1'b1;
        s = 0;
        for (int n = 0; n < 56; n++) begin
            sb.push_back(expect_at(s, (s < 32) ? 16'h0001 : 16'h0F00,
                                   (s >= 5 && s < 32), 1'b1, 1'b0, 2));
            @(posedge clk); #1;
            got = {j_out, row_out, count, frame_start, pending};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL restart s=%0d got=%b exp=%b", s, got, exp);
            end
            s++;
            load = (s == 5) || (s == 9);
            in_m = (s == 9) ? 16'h0F00 : 16'hF000;
        end
        load = 1'b0;
    endtask

    task automatic test_polarity();
        obs_t got, exp;
        int   s2;
        exp.j = 4'b0000; exp.r = 4'b1111; exp.c = 2'd0; exp.fs = 1'b0; exp.pd = 1'b0;
        sb.push_back(exp);
        @(posedge clk); #1;
        got = {j_out2, row_out2, count2, frame_start2, pending2};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL polarity_reset got=%b exp=%b", got, exp);
        end
        reset2 = 1'b0; enable2 = 1'b1; load2 = 1'b1; in2 = 16'h000F;
        s2 = 0;
        for (int n = 0; n < 64; n++) begin
            sb.push_back(expect_at(s2, 16'h000F, 1'b0, 1'b0, 1'b1, 0));
            @(posedge clk); #1;
            got = {j_out2, row_out2, count2, frame_start2, pending2};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL polarity s=%0d got=%b exp=%b", s2, got, exp);
            end
            s2++;
            load2 = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b0; in_m = '0;
        reset2 = 1'b1; enable2 = 1'b0; load2 = 1'b0; in2 = '0;
        s = 0;
        test_reset();
        test_scan();
        test_double_buffer();
        test_coincident();
        test_enable_drop();
        test_polarity();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

endmodule
